simon_host_ctrl: RTL

//  Host-side initiator for the SIMON_96144 core handshake (newKey/loadKey, newData/loadData, doneData/readData).

---
 rtl/simon_host_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/simon_host_ctrl.sv
// Host-side initiator for a SIMON_96144 core: buffers blocks in/out through small FIFOs and
// sequences the newKey/loadKey, newData/loadData and doneData/readData handshakes.
module simon_host_ctrl #(
  parameter int N     = 48,
  parameter int M     = 3,
  parameter int DEPTH = 4,
  parameter int HOLD  = 2
) (
  input  logic             clk,
  input  logic             nR,
  input  logic             key_wr,
  input  logic [M*N-1:0]   key_in,
  input  logic             mode_in,
  output logic             key_busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_block,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_block,
  output logic             newKey,
  output logic             newData,
  output logic             enc_dec,
  output logic             readData,
  output logic [2*N-1:0]   BLOCK,
  output logic [M*N-1:0]   KEY,
  input  logic             loadKey,
  input  logic             loadData,
  input  logic             doneData,
  input  logic [2*N-1:0]   outData
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

  typedef enum logic [1:0] {K_IDLE, K_REQ, K_HOLD} k_state_t;
  typedef enum logic [2:0] {D_IDLE, D_REQ, D_LHOLD, D_WAIT, D_DHOLD, D_READ, D_RHOLD} d_state_t;

  k_state_t         k_state_reg, k_state_next;
  d_state_t         d_state_reg, d_state_next;
  logic [CW-1:0]    k_cnt_reg, k_cnt_next;
  logic [CW-1:0]    d_cnt_reg, d_cnt_next;
  logic             key_loaded_reg, key_loaded_next;
  logic             done_pend_reg, done_pend_next;
  logic             new_key_reg, new_key_next;
  logic             new_data_reg, new_data_next;
  logic             read_data_reg, read_data_next;
  logic             enc_dec_reg, enc_dec_next;
  logic [2*N-1:0]   block_reg, block_next;
  logic [M*N-1:0]   key_reg, key_next;
  logic             ready_en_reg;
  logic             load_key_q, load_data_q, done_data_q;

  logic [2*N-1:0]   in_mem  [DEPTH];
  logic [2*N-1:0]   out_mem [DEPTH];
  logic [PW-1:0]    in_wr_ptr_reg, in_rd_ptr_reg;
  logic [PW-1:0]    out_wr_ptr_reg, out_rd_ptr_reg;

  logic in_full, in_empty, out_full, out_empty;
  logic in_push, in_pop, out_push, out_pop;
  logic lk_rise, ld_rise, dd_rise, key_accept;

  assign in_full   = (in_wr_ptr_reg[AW] != in_rd_ptr_reg[AW]) &&
                     (in_wr_ptr_reg[AW-1:0] == in_rd_ptr_reg[AW-1:0]);
  assign in_empty  = (in_wr_ptr_reg == in_rd_ptr_reg);
  assign out_full  = (out_wr_ptr_reg[AW] != out_rd_ptr_reg[AW]) &&
                     (out_wr_ptr_reg[AW-1:0] == out_rd_ptr_reg[AW-1:0]);
  assign out_empty = (out_wr_ptr_reg == out_rd_ptr_reg);

  // ready_en keeps in_ready low while reset is asserted, even though the FIFO reads empty
  assign in_ready  = ready_en_reg & ~in_full;
  assign in_push   = in_valid & in_ready;
  assign out_valid = ~out_empty;
  assign out_pop   = out_valid & out_ready;
  assign out_block = out_valid ? out_mem[out_rd_ptr_reg[AW-1:0]] : '0;

  assign lk_rise = loadKey  & ~load_key_q;
  assign ld_rise = loadData & ~load_data_q;
  assign dd_rise = doneData & ~done_data_q;

  // A new key is only taken with both handshakes quiescent; it wins over a block pop that cycle
  assign key_accept = key_wr && (k_state_reg == K_IDLE) && (d_state_reg == D_IDLE);

  assign key_busy = (k_state_reg != K_IDLE);
  assign newKey   = new_key_reg;
  assign newData  = new_data_reg;
  assign readData = read_data_reg;
  assign enc_dec  = enc_dec_reg;
  assign BLOCK    = block_reg;
  assign KEY      = key_reg;

  always_comb begin
    k_state_next    = k_state_reg;
    d_state_next    = d_state_reg;
    k_cnt_next      = k_cnt_reg;
    d_cnt_next      = d_cnt_reg;
    key_loaded_next = key_loaded_reg;
    done_pend_next  = done_pend_reg;
    new_key_next    = new_key_reg;
    new_data_next   = new_data_reg;
    read_data_next  = read_data_reg;
    enc_dec_next    = enc_dec_reg;
    block_next      = block_reg;
    key_next        = key_reg;
    in_pop          = 1'b0;
    out_push        = 1'b0;

    case (k_state_reg)
      K_IDLE: if (key_accept) begin
        key_next        = key_in;
        enc_dec_next    = mode_in;
        new_key_next    = 1'b1;
        key_loaded_next = 1'b0;
        k_state_next    = K_REQ;
      end
      K_REQ: if (lk_rise) begin
        k_cnt_next   = '0;
        k_state_next = K_HOLD;
      end
      K_HOLD: if (k_cnt_reg == HOLD_LAST) begin
        new_key_next    = 1'b0;
        key_loaded_next = 1'b1;
        k_state_next    = K_IDLE;
      end else begin
        k_cnt_next = k_cnt_reg + CW'(1);
      end
      default: k_state_next = K_IDLE;
    endcase

    case (d_state_reg)
      D_IDLE: if (key_loaded_reg && !key_accept && !in_empty) begin
        in_pop        = 1'b1;
        block_next    = in_mem[in_rd_ptr_reg[AW-1:0]];
        new_data_next = 1'b1;
        d_state_next  = D_REQ;
      end
      D_REQ: if (ld_rise) begin
        d_cnt_next   = '0;
        d_state_next = D_LHOLD;
      end
      D_LHOLD: if (d_cnt_reg == HOLD_LAST) begin
        new_data_next = 1'b0;
        d_state_next  = D_WAIT;
      end else begin
        d_cnt_next = d_cnt_reg + CW'(1);
      end
      // The done edge is remembered while the output FIFO is full; the core holds outData meanwhile
      D_WAIT: if (dd_rise || done_pend_reg) begin
        if (out_full) begin
          done_pend_next = 1'b1;
        end else begin
          done_pend_next = 1'b0;
          d_cnt_next     = '0;
          d_state_next   = D_DHOLD;
        end
      end
      D_DHOLD: if (d_cnt_reg == HOLD_LAST) begin
        out_push       = 1'b1;
        read_data_next = 1'b1;
        d_state_next   = D_READ;
      end else begin
        d_cnt_next = d_cnt_reg + CW'(1);
      end
      D_READ: if (!doneData) begin
        d_cnt_next   = '0;
        d_state_next = D_RHOLD;
      end
      D_RHOLD: if (d_cnt_reg == HOLD_LAST) begin
        read_data_next = 1'b0;
        d_state_next   = D_IDLE;
      end else begin
        d_cnt_next = d_cnt_reg + CW'(1);
      end
      default: d_state_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      k_state_reg    <= K_IDLE;
      d_state_reg    <= D_IDLE;
      k_cnt_reg      <= '0;
      d_cnt_reg      <= '0;
      key_loaded_reg <= 1'b0;
      done_pend_reg  <= 1'b0;
      new_key_reg    <= 1'b0;
      new_data_reg   <= 1'b0;
      read_data_reg  <= 1'b0;
      enc_dec_reg    <= 1'b0;
      block_reg      <= '0;
      key_reg        <= '0;
      ready_en_reg   <= 1'b0;
      load_key_q     <= 1'b0;
      load_data_q    <= 1'b0;
      done_data_q    <= 1'b0;
      in_wr_ptr_reg  <= '0;
      in_rd_ptr_reg  <= '0;
      out_wr_ptr_reg <= '0;
      out_rd_ptr_reg <= '0;
    end else begin
      k_state_reg    <= k_state_next;
      d_state_reg    <= d_state_next;
      k_cnt_reg      <= k_cnt_next;
      d_cnt_reg      <= d_cnt_next;
      key_loaded_reg <= key_loaded_next;
      done_pend_reg  <= done_pend_next;
      new_key_reg    <= new_key_next;
      new_data_reg   <= new_data_next;
      read_data_reg  <= read_data_next;
      enc_dec_reg    <= enc_dec_next;
      block_reg      <= block_next;
      key_reg        <= key_next;
      ready_en_reg   <= 1'b1;
      load_key_q     <= loadKey;
      load_data_q    <= loadData;
      done_data_q    <= doneData;
      in_wr_ptr_reg  <= in_wr_ptr_reg  + PW'(in_push);
      in_rd_ptr_reg  <= in_rd_ptr_reg  + PW'(in_pop);
      out_wr_ptr_reg <= out_wr_ptr_reg + PW'(out_push);
      out_rd_ptr_reg <= out_rd_ptr_reg + PW'(out_pop);
    end
  end

  // Storage needs no reset: pointers alone decide what is visible
  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr_ptr_reg[AW-1:0]]   <= in_block;
    if (out_push) out_mem[out_wr_ptr_reg[AW-1:0]] <= outData;
  end

endmodule
